// File: rtl/sm_np_pkg.sv
// Shared constants and helpers for the N-state x-event sequencer.
package sm_np_pkg;

    localparam int          SM_NP_MAX_STATES = 16;
    localparam int          SM_NP_STATE_W    = 4;
    localparam logic [15:0] SM_NP_Y_MASK     = 16'hAAAA;

    typedef logic [SM_NP_STATE_W-1:0] sm_state_t;

    // Pattern bit for a state index; anything past the 16-entry mask reads as 0.
    function automatic logic pat_bit(input logic [15:0] mask, input int unsigned idx);
        logic [31:0] i;
        i = 32'(idx);
        return (i < 32'd16) ? mask[i[3:0]] : 1'b0;
    endfunction

endpackage

// File: rtl/sm_np_seq_if.sv
// Control/status bundle of the sequencer: event and modulus load in, pattern and flags out.
interface sm_np_seq_if #(parameter int STATE_W = 4);

    logic               x;
    logic               mod_ld;
    logic [STATE_W-1:0] mod_in;
    logic               y;
    logic [STATE_W-1:0] state_o;
    logic               wrap;
    logic               mod_err;

    modport master (output x, mod_ld, mod_in, input y, state_o, wrap, mod_err);
    modport slave  (input x, mod_ld, mod_in, output y, state_o, wrap, mod_err);

endinterface

// File: rtl/sm_edge_det.sv
// Rising-edge detector: one flop of history, rise is combinational so no extra output latency.
module sm_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_q;

    // Remember last cycle's input; cleared so a high input right after reset counts as an edge.
    always_ff @(posedge clk) begin
        if (!reset) d_q <= 1'b0;
        else        d_q <= d;
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/sm_np_seq.sv
// N-state event sequencer: counts qualified x events modulo a runtime modulus and
// drives y from a per-state mask. Define SM_NP_EDGE_EN to count x rising edges
// instead of every cycle x is high.
module sm_np_seq
    import sm_np_pkg::*;
#(
    parameter int          NUM_STATES = 8,
    parameter int          STATE_W    = SM_NP_STATE_W,
    parameter logic [15:0] Y_MASK     = SM_NP_Y_MASK
) (
    input  logic        clk,
    input  logic        reset,
    sm_np_seq_if.slave  bus
);

    localparam logic [STATE_W-1:0] ONE     = STATE_W'(1);
    localparam logic [STATE_W-1:0] TWO     = STATE_W'(2);
    localparam logic [STATE_W-1:0] MOD_MAX = STATE_W'(NUM_STATES);

    logic [STATE_W-1:0] state, state_n;
    logic [STATE_W-1:0] mod_r, mod_n;
    logic               y_r, y_n;
    logic               wrap_r, wrap_n;
    logic               err_r, err_n;
    logic               adv;
    logic               ld_ok;

`ifdef SM_NP_EDGE_EN
    sm_edge_det u_edge (
        .clk   (clk),
        .reset (reset),
        .d     (bus.x),
        .rise  (adv)
    );
`else
    assign adv = bus.x;
`endif

    // Next state: an accepted load wins and swallows a same-cycle event; a rejected
    // load only flags the error and lets the event through.
    always_comb begin
        state_n = state;
        mod_n   = mod_r;
        wrap_n  = 1'b0;
        err_n   = 1'b0;
        ld_ok   = bus.mod_ld && (bus.mod_in >= TWO) && (bus.mod_in <= MOD_MAX);
        if (ld_ok) begin
            mod_n   = bus.mod_in;
            state_n = '0;
        end else begin
            err_n = bus.mod_ld;
            if (adv) begin
                if (state == mod_r - ONE) begin
                    state_n = '0;
                    wrap_n  = 1'b1;
                end else begin
                    state_n = state + ONE;
                end
            end
        end
        y_n = pat_bit(Y_MASK, 32'(state_n));
    end

    // Single register bank so y and state_o always change on the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= '0;
            mod_r  <= MOD_MAX;
            y_r    <= Y_MASK[0];
            wrap_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            state  <= state_n;
            mod_r  <= mod_n;
            y_r    <= y_n;
            wrap_r <= wrap_n;
            err_r  <= err_n;
        end
    end

    assign bus.state_o = state;
    assign bus.y       = y_r;
    assign bus.wrap    = wrap_r;
    assign bus.mod_err = err_r;

endmodule

// File: tb/tb_sm_np_seq.sv
// Directed bench for sm_np_seq with default parameters (8 states, mask AAAA).
module tb_sm_np_seq;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    sm_np_seq_if #(.STATE_W(4)) bus ();

    sm_np_seq #(.NUM_STATES(8), .STATE_W(4), .Y_MASK(16'hAAAA)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs for one clock, then sample 1 time unit after the edge.
    task automatic step(input logic x, input logic ld, input logic [3:0] m);
        bus.x = x; bus.mod_ld = ld; bus.mod_in = m;
        @(posedge clk); #1;
    endtask

    task automatic chk_all(input string tag, input int st, input logic yv,
                           input logic wr, input logic er);
        chk({tag, ".state"}, 32'(bus.state_o), 32'(st));
        chk({tag, ".y"},     32'(bus.y),       32'(yv));
        chk({tag, ".wrap"},  32'(bus.wrap),    32'(wr));
        chk({tag, ".err"},   32'(bus.mod_err), 32'(er));
    endtask

    initial begin
        reset = 1'b0;
        bus.x = 1'b0; bus.mod_ld = 1'b0; bus.mod_in = 4'd0;
        @(posedge clk); #1;
        step(1'b1, 1'b0, 4'd0);          // reset dominates x
        chk_all("reset", 0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;

`ifdef SM_NP_EDGE_EN
        // Held x counts once.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 4'd0);
            chk_all($sformatf("hold%0d", i), 1, 1'b1, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 4'd0);
        chk_all("low", 1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'd0); chk_all("tog1", 2, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'd0); chk_all("tog2", 2, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'd0); chk_all("tog3", 3, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'd0); chk_all("tog4", 3, 1'b1, 1'b0, 1'b0);
`else
        // 1: eight level events, wrap only on 7 -> 0.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 4'd0);
            chk_all($sformatf("cnt%0d", i), i % 8, 1'((i % 8) & 1), 1'(i == 8), 1'b0);
        end
        for (int i = 1; i <= 7; i++) step(1'b1, 1'b0, 4'd0);
        chk_all("to7", 7, 1'b1, 1'b0, 1'b0);
        // 2: no events, last state holds.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 4'd0);
            chk_all($sformatf("hold%0d", i), 7, 1'b1, 1'b0, 1'b0);
        end
        // 3: load modulus 3 in state 5 with a same-cycle event.
        step(1'b1, 1'b0, 4'd0);
        chk_all("wrap7", 0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'd0);
        chk_all("at5", 5, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 4'd3);
        chk_all("ld3", 0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'd0); chk_all("m3a", 1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'd0); chk_all("m3b", 2, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'd0); chk_all("m3c", 0, 1'b0, 1'b1, 1'b0);
        // 4: rejected loads pulse mod_err, event still processed.
        step(1'b0, 1'b1, 4'd1); chk_all("bad1", 0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 4'd0); chk_all("bad1q", 0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 4'd9); chk_all("bad9", 1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 4'd0); chk_all("bad9q", 1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 4'd0); chk_all("bad0", 2, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 4'd0); chk_all("stillm3", 0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 4'd0); chk_all("m3d", 1, 1'b1, 1'b0, 1'b0);
        // 5: reset mid-count restores modulus 8.
        reset = 1'b0;
        step(1'b1, 1'b1, 4'd2);
        chk_all("midrst", 0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        for (int i = 1; i <= 7; i++) step(1'b1, 1'b0, 4'd0);
        chk_all("m8at7", 7, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'd0); chk_all("m8wrap", 0, 1'b0, 1'b1, 1'b0);
        // Modulus 2: toggle, wrap every second event.
        step(1'b0, 1'b1, 4'd2); chk_all("ld2", 0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 1'b0, 4'd0);
            chk_all($sformatf("m2_%0d", i), i % 2, 1'(i % 2), 1'(i % 2 == 0), 1'b0);
        end
        // Maximum modulus accepted.
        step(1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b1, 4'd8); chk_all("ld8", 0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 7; i++) step(1'b1, 1'b0, 4'd0);
        chk_all("ld8at7", 7, 1'b1, 1'b0, 1'b0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
